sa_miss_handler: RTL and testbench
==================================

SA_MISS_HANDLER -- requirements
Module: sa_miss_handler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, fill-response watchdog limit in cycles (valid only under MISS_TIMEOUT_EN).
REQ-002 SHALL have clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have cache_miss  in  1  miss request from sa_cache.
REQ-005 SHALL have i_tag  in  18, i_index  in  8, i_offset  in  6  miss address fields.
REQ-006 SHALL have i_evict  in  1, i_evict_addr  in  32, i_evict_data  in  32  dirty victim from sa_cache.
REQ-007 SHALL have o_memory_line  out  32, o_memory_response  out  1  refill data and strobe to sa_cache.
REQ-008 SHALL have o_busy  out  1  high in every state except IDLE.
REQ-009 SHALL have mem_req_valid  out  1, mem_req_ready  in  1, mem_req_we  out  1, mem_req_addr  out  32, mem_req_wdata  out  32  backing-memory request channel.
REQ-010 SHALL have mem_rsp_valid  in  1, mem_rsp_data  in  32  backing-memory read response.
REQ-011 SHALL have o_error  out  1  refill timeout strobe.

Function
REQ-012 SHALL implement FSM states IDLE, FILL_REQ, FILL_WAIT, RESP, WB_REQ.
REQ-013 IDLE: on edge with cache_miss=1, SHALL latch fill address {i_tag,i_index,6'b0} and go to FILL_REQ; cache_miss ignored in all other states.
REQ-014 On the same accepting edge, if i_evict=1, SHALL latch i_evict_addr/i_evict_data into a 1-entry write-back buffer and set wb_valid; i_evict outside an accepting edge ignored.
REQ-015 FILL_REQ: mem_req_valid=1, mem_req_we=0, mem_req_addr=fill address, mem_req_wdata=0; transfer occurs on edge with mem_req_valid&mem_req_ready; then FILL_WAIT. Request fields SHALL stay stable while ready=0.
REQ-016 FILL_WAIT: on edge with mem_rsp_valid=1 SHALL latch mem_rsp_data, go to RESP; mem_rsp_valid in any other state ignored.
REQ-017 RESP: o_memory_response=1 for exactly one cycle with o_memory_line=latched data; next state WB_REQ if wb_valid else IDLE.
REQ-018 o_memory_line SHALL hold the last refilled value until the next refill; o_memory_response low outside RESP.
REQ-019 WB_REQ: mem_req_valid=1, mem_req_we=1, addr/wdata from buffer; on handshake clear wb_valid, go IDLE; no response expected for writes.
REQ-020 Minimum miss latency: acceptance edge N, response strobe high in cycle N+3 (ready and rsp_valid both immediate).
REQ-021 Fill SHALL always be issued before write-back; o_busy stays high through WB_REQ, so a new miss cannot target a still-buffered victim.
REQ-022 mem_req_valid SHALL be low in IDLE, FILL_WAIT, RESP.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, wb_valid=0, all outputs 0 (o_memory_line=0, mem_req_*=0, o_busy=0, o_error=0, o_memory_response=0), watchdog=0.
REQ-024 Reset mid-transaction SHALL abandon it; no request or strobe issued after rst deasserts until a new cache_miss.

Configuration
REQ-025 With MISS_TIMEOUT_EN defined: 8-bit watchdog counts cycles in FILL_WAIT, cleared on entry; on reaching TIMEOUT without mem_rsp_valid SHALL go RESP with o_memory_line=0 and o_error=1 for that one cycle only; write-back then proceeds normally.
REQ-026 Without MISS_TIMEOUT_EN: no watchdog, FILL_WAIT waits indefinitely, o_error tied 0.

Verification
REQ-027 Clean miss: cache_miss, tag=0x00001, index=0x02, i_evict=0; ready=1, rsp_valid next cycle with 0xCAFEF00D -> mem_req_addr=0x00004080 we=0, o_memory_response pulse N+3 with 0xCAFEF00D, back to IDLE, no write issued.
REQ-028 Miss with evict addr 0x12340000 data 0xA5A5A5A5 -> read handshake first, response strobe, then write we=1 addr 0x12340000 wdata 0xA5A5A5A5, then o_busy=0.
REQ-029 Backpressure: mem_req_ready low 4 cycles in FILL_REQ and WB_REQ -> valid held, addr/wdata stable, exactly one handshake each.
REQ-030 Ignored inputs: cache_miss and mem_rsp_valid pulsed during FILL_REQ/RESP -> no state change, no extra strobe.
REQ-031 Reset in FILL_WAIT with wb_valid=1 -> outputs 0 immediately, no write-back after release.
REQ-032 MISS_TIMEOUT_EN, TIMEOUT=8, no response -> o_error and o_memory_response high together 8 cycles after FILL_WAIT entry, o_memory_line=0; without macro -> stays in FILL_WAIT, o_busy=1.

Source files
------------

// File: rtl/sa_miss_handler.sv
// Miss handler for sa_cache: issues the line fill, returns refill data, then drains one buffered dirty victim.
// Optional refill watchdog enabled by defining MISS_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for cache_miss
// FILL_REQ  | read request presented to backing memory
// FILL_WAIT | waiting for read response (or watchdog expiry)
// RESP      | one-cycle refill strobe to sa_cache
// WB_REQ    | write request for the buffered victim
module sa_miss_handler #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cache_miss,
   input  logic [17:0] i_tag,
   input  logic [7:0]  i_index,
   input  logic [5:0]  i_offset,
   input  logic        i_evict,
   input  logic [31:0] i_evict_addr,
   input  logic [31:0] i_evict_data,
   output logic [31:0] o_memory_line,
   output logic        o_memory_response,
   output logic        o_busy,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        o_error
);

   typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, RESP, WB_REQ} state_t;

   state_t      state_q, state_d;
   logic [31:0] fill_addr_q, fill_addr_d;
   logic        wb_valid_q, wb_valid_d;
   logic [31:0] wb_addr_q, wb_addr_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [31:0] line_q, line_d;

   // Fills are always line aligned, so the offset is not needed.
   logic unused_offset;
   assign unused_offset = ^i_offset;

`ifdef MISS_TIMEOUT_EN
   logic [7:0] wd_q, wd_d;
   logic       err_q, err_d;
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         fill_addr_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         line_q      <= '0;
`ifdef MISS_TIMEOUT_EN
         wd_q        <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         wb_valid_q  <= wb_valid_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         line_q      <= line_d;
`ifdef MISS_TIMEOUT_EN
         wd_q        <= wd_d;
         err_q       <= err_d;
`endif
      end
   end

   always_comb begin
      state_d           = state_q;
      fill_addr_d       = fill_addr_q;
      wb_valid_d        = wb_valid_q;
      wb_addr_d         = wb_addr_q;
      wb_data_d         = wb_data_q;
      line_d            = line_q;
      mem_req_valid     = 1'b0;
      mem_req_we        = 1'b0;
      mem_req_addr      = '0;
      mem_req_wdata     = '0;
      o_memory_response = 1'b0;
`ifdef MISS_TIMEOUT_EN
      wd_d              = wd_q;
      err_d             = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (cache_miss) begin
               fill_addr_d = {i_tag, i_index, 6'b0};
               if (i_evict) begin
                  wb_valid_d = 1'b1;
                  wb_addr_d  = i_evict_addr;
                  wb_data_d  = i_evict_data;
               end
               state_d = FILL_REQ;
            end
         end
         FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = fill_addr_q;
            if (mem_req_ready) begin
               state_d = FILL_WAIT;
`ifdef MISS_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end
         FILL_WAIT: begin
            if (mem_rsp_valid) begin
               line_d  = mem_rsp_data;
               state_d = RESP;
            end
`ifdef MISS_TIMEOUT_EN
            // Expiry returns a zero line flagged by o_error for the strobe cycle.
            else if (wd_q == 8'(TIMEOUT - 1)) begin
               line_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wd_d = wd_q + 8'd1;
            end
`endif
         end
         RESP: begin
            o_memory_response = 1'b1;
            state_d           = wb_valid_q ? WB_REQ : IDLE;
`ifdef MISS_TIMEOUT_EN
            err_d             = 1'b0;
`endif
         end
         WB_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = wb_addr_q;
            mem_req_wdata = wb_data_q;
            if (mem_req_ready) begin
               wb_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_memory_line = line_q;
   assign o_busy        = (state_q != IDLE);
`ifdef MISS_TIMEOUT_EN
   assign o_error       = err_q;
`else
   assign o_error       = 1'b0;
`endif

endmodule

// File: tb/tb_sa_miss_handler.sv
// Scoreboard bench for sa_miss_handler: stimulus pushes expected memory requests and refill strobes,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_sa_miss_handler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cache_miss = 1'b0;
   logic [17:0] i_tag = '0;
   logic [7:0]  i_index = '0;
   logic [5:0]  i_offset = '0;
   logic        i_evict = 1'b0;
   logic [31:0] i_evict_addr = '0;
   logic [31:0] i_evict_data = '0;
   logic [31:0] o_memory_line;
   logic        o_memory_response;
   logic        o_busy;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        o_error;

   sa_miss_handler #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .cache_miss(cache_miss), .i_tag(i_tag), .i_index(i_index),
      .i_offset(i_offset), .i_evict(i_evict), .i_evict_addr(i_evict_addr),
      .i_evict_data(i_evict_data), .o_memory_line(o_memory_line),
      .o_memory_response(o_memory_response), .o_busy(o_busy), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .o_error(o_error)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_RSP = 2'd2;
   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  resp_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d, input logic e);
      ev_t ev;
      ev.kind = k; ev.addr = a; ev.data = d; ev.err = e;
      exp_q.push_back(ev);
   endtask

   task automatic score(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d, input logic e);
      ev_t ev;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h required none", k, a, d);
      end else begin
         ev = exp_q.pop_front();
         chk("event_kind", 32'(k), 32'(ev.kind));
         chk("event_addr", a, ev.addr);
         chk("event_data", d, ev.data);
         chk("event_err", 32'(e), 32'(ev.err));
      end
   endtask

   // Monitor: handshakes and strobes are sampled mid-cycle, away from the active edge.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic        prev_we;
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (mem_req_valid && mem_req_ready)
            score(mem_req_we ? K_WR : K_RD, mem_req_addr, mem_req_wdata, 1'b0);
         if (o_memory_response) begin
            resp_cyc = cyc;
            score(K_RSP, 32'h0, o_memory_line, o_error);
         end
         if (o_error && !o_memory_response)
            chk("error_without_strobe", 32'(o_error), 32'h0);
         if (prev_stall) begin
            chk("stall_valid_held", 32'(mem_req_valid), 32'h1);
            chk("stall_addr_stable", mem_req_addr, prev_addr);
            chk("stall_wdata_stable", mem_req_wdata, prev_wdata);
            chk("stall_we_stable", 32'(mem_req_we), 32'(prev_we));
         end
         prev_stall = mem_req_valid && !mem_req_ready;
         prev_addr  = mem_req_addr;
         prev_wdata = mem_req_wdata;
         prev_we    = mem_req_we;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_miss(input logic [17:0] tag, input logic [7:0] idx, input logic ev,
                             input logic [31:0] ea, input logic [31:0] ed);
      cache_miss   = 1'b1;
      i_tag        = tag;
      i_index      = idx;
      i_offset     = 6'h2B;
      i_evict      = ev;
      i_evict_addr = ea;
      i_evict_data = ed;
   endtask

   // Full miss with optional evict, request backpressure, response delay and ignored-input pokes.
   task automatic run_miss(input logic [17:0] tag, input logic [7:0] idx, input logic [31:0] fill_addr,
                           input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                           input int stall_f, input int stall_w, input int rsp_dly,
                           input logic [31:0] rd, input logic poke);
      int acc;
      push(K_RD, fill_addr, 32'h0, 1'b0);
      push(K_RSP, 32'h0, rd, 1'b0);
      if (ev) push(K_WR, ea, ed, 1'b0);
      resp_cyc = -1;
      mem_req_ready = (stall_f == 0);
      start_miss(tag, idx, ev, ea, ed);
      tick();
      acc = cyc;
      cache_miss = 1'b0;
      i_evict = 1'b0;
      i_evict_addr = 32'hFFFF_0000;
      for (int i = 0; i < stall_f; i++) begin
         cache_miss    = poke;
         mem_rsp_valid = poke;
         mem_rsp_data  = 32'hBAD0_0001;
         tick();
      end
      cache_miss    = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      for (int i = 0; i < rsp_dly; i++) tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rd;
      tick();
      cache_miss    = poke;
      mem_rsp_valid = poke;
      mem_rsp_data  = 32'hBAD0_0002;
      tick();
      cache_miss    = 1'b0;
      mem_rsp_valid = 1'b0;
      if (ev) begin
         mem_req_ready = (stall_w == 0);
         for (int i = 0; i < stall_w; i++) tick();
         mem_req_ready = 1'b1;
         tick();
      end
      tick();
      // acc is edge N; the strobe is sampled high at edge N+3 when nothing stalls.
      chk("resp_latency", 32'(resp_cyc - acc), 32'(stall_f + rsp_dly + 2));
      chk("idle_busy", 32'(o_busy), 32'h0);
      chk("line_hold", o_memory_line, rd);
   endtask

   initial begin
      int e;
      #12;
      chk("rst_outputs", {o_memory_line, mem_req_addr, mem_req_wdata}, 32'h0);
      chk("rst_flags", {26'h0, o_memory_response, o_busy, mem_req_valid, mem_req_we, o_error, 1'b0}, 32'h0);
      @(posedge clk); #1 rst = 1'b1;
      tick();

      run_miss(18'h00001, 8'h02, 32'h0000_4080, 1'b0, 32'h7777_0000, 32'h1, 0, 0, 0, 32'hCAFE_F00D, 1'b0);
      run_miss(18'h2AB3C, 8'h5D, 32'hAACF_1740, 1'b1, 32'h1234_0000, 32'hA5A5_A5A5, 0, 0, 2, 32'h1122_3344, 1'b0);
      run_miss(18'h3FFFF, 8'hFF, 32'hFFFF_FFC0, 1'b1, 32'hDEAD_BEE0, 32'h0BAD_CAFE, 4, 4, 1, 32'h5566_7788, 1'b0);
      run_miss(18'h00010, 8'h80, 32'h0004_2000, 1'b1, 32'h0000_0100, 32'h600D_0001, 3, 0, 0, 32'h9ABC_DEF0, 1'b1);

      // Reset in FILL_WAIT with a buffered victim: everything drops at once and nothing follows.
      push(K_RD, 32'h0000_0040, 32'h0, 1'b0);
      start_miss(18'h0, 8'h01, 1'b1, 32'h5555_0000, 32'h0000_0077);
      tick();
      cache_miss = 1'b0; i_evict = 1'b0;
      tick();
      #2 rst = 1'b0;
      #1;
      chk("midrst_line", o_memory_line, 32'h0);
      chk("midrst_req", {mem_req_addr | mem_req_wdata}, 32'h0);
      chk("midrst_flags", {27'h0, o_memory_response, o_busy, mem_req_valid, mem_req_we, o_error}, 32'h0);
      tick();
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h0000_0099;
      tick();
      mem_rsp_valid = 1'b0;
      repeat (10) tick();
      chk("postrst_busy", 32'(o_busy), 32'h0);
      chk("postrst_line", o_memory_line, 32'h0);

      // Refill that never answers.
      push(K_RD, 32'h0000_F0C0, 32'h0, 1'b0);
`ifdef MISS_TIMEOUT_EN
      push(K_RSP, 32'h0, 32'h0, 1'b1);
      push(K_WR, 32'h0000_F000, 32'h1357_9BDF, 1'b0);
`endif
      resp_cyc = -1;
      start_miss(18'h3, 8'hC3, 1'b1, 32'h0000_F000, 32'h1357_9BDF);
      tick();
      cache_miss = 1'b0; i_evict = 1'b0;
      tick();
      e = cyc;
      repeat (12) tick();
`ifdef MISS_TIMEOUT_EN
      chk("timeout_latency", 32'(resp_cyc - e), 32'd8);
      chk("timeout_busy", 32'(o_busy), 32'h0);
      chk("timeout_line", o_memory_line, 32'h0);
`else
      chk("nowd_busy", 32'(o_busy), 32'h1);
      chk("nowd_error", 32'(o_error), 32'h0);
      chk("nowd_strobe", 32'(resp_cyc), 32'hFFFF_FFFF);
      #2 rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
`endif

      run_miss(18'h00ABC, 8'h11, 32'h02AF_0440, 1'b0, 32'h0, 32'h0, 0, 0, 0, 32'h0F0F_0F0F, 1'b0);

      repeat (3) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
